// File: rtl/find_bkt_lvl_ctrl_pkg.sv
// Shared sat-engine package for the backtrack-level search controller.
// Holds the FSM state encoding and the default level/bin widths.
package find_bkt_lvl_ctrl_pkg;

  localparam int unsigned WidthLvlDef = 16;
  localparam int unsigned WidthBinDef = 10;
  localparam int unsigned BktCntWidth = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StApply = 2'd2,
    StUnsat = 2'd3
  } bkt_state_e;

endpackage

// File: rtl/find_bkt_lvl_ctrl_if.sv
// Level-state read port between the backtrack search controller and the level-state array.
// The read is combinational: data for lvl_rd_addr is returned in the same cycle.
//   lvl_rd_addr : level being read (driven by the controller, master)
//   lvl_dcd_bin : decision bin of the addressed level (driven by the array, slave)
//   lvl_has_bkt : has-backtracked flag of the addressed level (driven by the array, slave)
interface find_bkt_lvl_ctrl_if #(
  parameter int unsigned WIDTH_LVL = 16,
  parameter int unsigned WIDTH_BIN = 10
);

  logic [WIDTH_LVL-1:0] lvl_rd_addr;
  logic [WIDTH_BIN-1:0] lvl_dcd_bin;
  logic                 lvl_has_bkt;

  modport master (
    output lvl_rd_addr,
    input  lvl_dcd_bin,
    input  lvl_has_bkt
  );

  modport slave (
    input  lvl_rd_addr,
    output lvl_dcd_bin,
    output lvl_has_bkt
  );

endinterface

// File: rtl/find_bkt_lvl_ctrl_bkt_stat_cnt.sv
// bkt_stat_cnt: saturating count of committed backtracks.
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : one-cycle increment request (apply pulse)
//   cnt_o    : current count, sticks at all-ones
module bkt_stat_cnt
  import find_bkt_lvl_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_i,
  output logic [BktCntWidth-1:0] cnt_o
);

  logic [BktCntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/find_bkt_lvl_ctrl.sv
// find_bkt_lvl_ctrl: searches downward from the current decision level for the first level
// that has not yet been backtracked, then commits it (APPLY) or reports UNSAT.
// Optional feature macro: BKT_STAT_EN (adds the saturating backtrack counter bkt_stat_cnt).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : start a search (IDLE only), max_lvl_i captured with it
//   abort_i       : cancel; returns to IDLE next cycle, suppresses done/apply this cycle
//   lvl_io        : level-state read port (master)
//   busy_o        : not in IDLE
//   apply_bkt_o   : one-cycle commit pulse
//   done_o        : one-cycle end-of-search pulse, unsat_o qualifies it
//   bkt_lvl_o/bkt_bin_o : found level and its decision bin, held until next find
//   bkt_cnt_o     : committed backtrack count (0 without BKT_STAT_EN)
module find_bkt_lvl_ctrl
  import find_bkt_lvl_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_LVL = WidthLvlDef,
  parameter int unsigned WIDTH_BIN = WidthBinDef
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [WIDTH_LVL-1:0]   max_lvl_i,
  input  logic                   abort_i,
  find_bkt_lvl_ctrl_if.master    lvl_io,
  output logic                   busy_o,
  output logic                   apply_bkt_o,
  output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]   bkt_bin_o,
  output logic                   done_o,
  output logic                   unsat_o,
  output logic [BktCntWidth-1:0] bkt_cnt_o
);

  localparam logic [WIDTH_LVL-1:0] LvlOne = WIDTH_LVL'(1);

  bkt_state_e           state_q, state_d;
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_BIN-1:0] bkt_bin_q, bkt_bin_d;

  always_comb begin
    state_d   = state_q;
    cur_lvl_d = cur_lvl_q;
    bkt_lvl_d = bkt_lvl_q;
    bkt_bin_d = bkt_bin_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_lvl_d = max_lvl_i;
          state_d   = (max_lvl_i != '0) ? StScan : StUnsat;
        end
      end
      StScan: begin
        if (!lvl_io.lvl_has_bkt) begin
          bkt_lvl_d = cur_lvl_q;
          bkt_bin_d = lvl_io.lvl_dcd_bin;
          state_d   = StApply;
        end else if (cur_lvl_q > LvlOne) begin
          cur_lvl_d = cur_lvl_q - LvlOne;
        end else begin
          // Level 0 is the root and can never be a backtrack target.
          state_d = StUnsat;
        end
      end
      StApply: state_d = StIdle;
      StUnsat: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a find in the same cycle.
    if (abort_i) begin
      state_d   = StIdle;
      cur_lvl_d = cur_lvl_q;
      bkt_lvl_d = bkt_lvl_q;
      bkt_bin_d = bkt_bin_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_lvl_q <= '0;
      bkt_lvl_q <= '0;
      bkt_bin_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_lvl_q <= cur_lvl_d;
      bkt_lvl_q <= bkt_lvl_d;
      bkt_bin_q <= bkt_bin_d;
    end
  end

  // Pulses decode straight from the state register; abort masks them in its own cycle.
  assign busy_o      = (state_q != StIdle);
  assign apply_bkt_o = (state_q == StApply) && !abort_i;
  assign unsat_o     = (state_q == StUnsat) && !abort_i;
  assign done_o      = apply_bkt_o || unsat_o;
  assign bkt_lvl_o   = bkt_lvl_q;
  assign bkt_bin_o   = bkt_bin_q;

  assign lvl_io.lvl_rd_addr = (state_q == StScan) ? cur_lvl_q : '0;

`ifdef BKT_STAT_EN
  bkt_stat_cnt u_bkt_stat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (apply_bkt_o),
    .cnt_o (bkt_cnt_o)
  );
`else
  assign bkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_find_bkt_lvl_ctrl.sv
module tb_find_bkt_lvl_ctrl;
  import find_bkt_lvl_ctrl_pkg::*;

  localparam int unsigned WL = 16;
  localparam int unsigned WB = 10;
`ifdef BKT_STAT_EN
  localparam int unsigned StatEn = 1;
`else
  localparam int unsigned StatEn = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WL-1:0] max_lvl;
  logic          abort;
  logic          busy, apply_bkt, done, unsat;
  logic [WL-1:0] bkt_lvl;
  logic [WB-1:0] bkt_bin;
  logic [15:0]   bkt_cnt;

  find_bkt_lvl_ctrl_if #(.WIDTH_LVL(WL), .WIDTH_BIN(WB)) lvl_if ();

  find_bkt_lvl_ctrl #(.WIDTH_LVL(WL), .WIDTH_BIN(WB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .max_lvl_i   (max_lvl),
    .abort_i     (abort),
    .lvl_io      (lvl_if.master),
    .busy_o      (busy),
    .apply_bkt_o (apply_bkt),
    .bkt_lvl_o   (bkt_lvl),
    .bkt_bin_o   (bkt_bin),
    .done_o      (done),
    .unsat_o     (unsat),
    .bkt_cnt_o   (bkt_cnt)
  );

  always #5 clk = ~clk;

  // Level-state array model, combinational read.
  logic          has_bkt [16];
  logic [WB-1:0] dcd_bin [16];
  always_comb begin
    lvl_if.lvl_has_bkt = has_bkt[lvl_if.lvl_rd_addr[3:0]];
    lvl_if.lvl_dcd_bin = dcd_bin[lvl_if.lvl_rd_addr[3:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          unsat;
    logic [WL-1:0] lvl;
    logic [WB-1:0] bin;
    int            start;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [WL-1:0] addr_q[$];
  logic [WL-1:0] last_lvl = '0;
  logic [WB-1:0] last_bin = '0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_apply = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_unexp(string name, logic [63:0] act);
    n_chk++;
    $display("FAIL %s: actual %0h required none (cycle %0d)", name, act, cyc);
  endfunction

  // Monitor: pops expected read addresses and search results as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (lvl_if.lvl_rd_addr != '0) begin
        if (addr_q.size() == 0) fail_unexp("rd_addr_unexpected", 64'(lvl_if.lvl_rd_addr));
        else check("rd_addr", 64'(lvl_if.lvl_rd_addr), 64'(addr_q.pop_front()));
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_unexp("done_unexpected", 64'(unsat));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("unsat", 64'(unsat), 64'(e.unsat));
          check("apply_with_done", 64'(apply_bkt), 64'(!e.unsat));
          check("bkt_lvl", 64'(bkt_lvl), 64'(e.lvl));
          check("bkt_bin", 64'(bkt_bin), 64'(e.bin));
          check("latency", 64'(cyc - e.start), 64'(e.lat));
        end
      end else if (apply_bkt) begin
        fail_unexp("apply_without_done", 64'(apply_bkt));
      end
    end
  end

  task automatic set_lvls(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      has_bkt[i] = mask[i];
      dcd_bin[i] = WB'(i * 11 + 5);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0 || busy) begin
      fail_unexp("search_timeout", 64'(exp_q.size()));
      exp_q.delete();
    end
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    addr_q.delete();
  endtask

  // Issues a search with hand-supplied outcome; poke re-pulses start mid-search.
  task automatic search(input logic [WL-1:0] mx, input bit exp_unsat,
                        input logic [WL-1:0] lvl, input bit poke);
    exp_t e;
    int   lo;
    @(posedge clk); #1;
    lo = exp_unsat ? 1 : int'(lvl);
    if (mx != '0) for (int a = int'(mx); a >= lo; a--) addr_q.push_back(WL'(a));
    if (!exp_unsat) begin
      last_lvl = lvl;
      last_bin = dcd_bin[lvl[3:0]];
      n_apply++;
    end
    e.unsat = exp_unsat;
    e.lvl   = last_lvl;
    e.bin   = last_bin;
    e.start = cyc;
    e.lat   = exp_unsat ? ((mx == '0) ? 1 : int'(mx) + 1) : int'(mx) - int'(lvl) + 2;
    exp_q.push_back(e);
    start   = 1'b1;
    max_lvl = mx;
    @(posedge clk); #1;
    start   = 1'b0;
    max_lvl = 16'hBEEF;
    if (poke) begin
      start   = 1'b1;
      max_lvl = 16'd9;
      @(posedge clk); #1;
      start   = 1'b0;
    end
    wait_drain(40);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_apply"}, 64'(apply_bkt), 64'd0);
    check({tag, "_unsat"}, 64'(unsat), 64'd0);
    check({tag, "_addr"}, 64'(lvl_if.lvl_rd_addr), 64'd0);
    check({tag, "_bkt_lvl"}, 64'(bkt_lvl), 64'd0);
    check({tag, "_bkt_bin"}, 64'(bkt_bin), 64'd0);
    check({tag, "_bkt_cnt"}, 64'(bkt_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; max_lvl = '0;
    set_lvls(16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Found at level 2 from max 3.
    set_lvls(16'hFFFB);
    dcd_bin[2] = 10'd37;
    search(16'd3, 1'b0, 16'd2, 1'b0);
    check("cnt_after_one", 64'(bkt_cnt), 64'(StatEn));

    // All levels backtracked: unsat after scanning 2,1.
    set_lvls(16'hFFFF);
    search(16'd2, 1'b1, 16'd0, 1'b0);

    // Max level 0: immediate unsat, no scan.
    search(16'd0, 1'b1, 16'd0, 1'b0);

    // Abort on the second SCAN cycle.
    set_lvls(16'hFFFF);
    @(posedge clk); #1;
    addr_q.push_back(16'd5);
    addr_q.push_back(16'd4);
    start = 1'b1; max_lvl = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    check("abort_cycle_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_addr", 64'(lvl_if.lvl_rd_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", 64'(busy), 64'd0);
    check("abort_addr_drained", 64'(addr_q.size()), 64'd0);
    check("abort_keeps_lvl", 64'(bkt_lvl), 64'd2);

    // Abort wins over a simultaneous start.
    start = 1'b1; abort = 1'b1; max_lvl = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", 64'(busy), 64'd0);

    // Reset mid-SCAN clears everything at once.
    addr_q.push_back(16'd5);
    start = 1'b1; max_lvl = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    last_lvl = '0; last_bin = '0; n_apply = 0;

    // Repeat of the first search after reset, then two more finds.
    set_lvls(16'hFFFB);
    dcd_bin[2] = 10'd37;
    search(16'd3, 1'b0, 16'd2, 1'b0);
    set_lvls(16'hFFFD);
    search(16'd1, 1'b0, 16'd1, 1'b0);
    set_lvls(16'hFFF7);
    search(16'd6, 1'b0, 16'd3, 1'b1);
    check("bkt_cnt_final", 64'(bkt_cnt), StatEn ? 64'(n_apply) : 64'd0);
    check("bkt_lvl_final", 64'(bkt_lvl), 64'd3);
    check("bkt_bin_final", 64'(bkt_bin), 64'd38);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
